// File: rtl/refi_agu_pkg.sv
// REFI address generator shared types: FSM state enum and default widths.
// Defaults track the project register-file and REFI field constants.
// No logic; types and constants only.
package refi_agu_pkg;
   import top_consts_types_package::*;

   localparam int DEF_ADDR_WIDTH = RF_ADDR_WIDTH;
   localparam int DEF_CNT_WIDTH  = REFI_FIELD_WIDTH;
   localparam int DEF_RF_DEPTH   = RF_DEPTH;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      INIT_DLY = 2'd1,
      ISSUE    = 2'd2,
      MID_DLY  = 2'd3
   } refi_state_t;
endpackage

// File: rtl/top_consts_types_package.sv
// Project-wide register-file and REFI instruction field constants.
// Shared by the address generators and their wrappers.
// No logic; constants only.
package top_consts_types_package;
   localparam int RF_ADDR_WIDTH    = 6;
   localparam int RF_DEPTH         = 64;
   localparam int REFI_FIELD_WIDTH = 6;
endpackage

// File: rtl/refi_agu_dly_cnt.sv
// Loadable down-counter used for both the initial and the middle delay.
// Latency: load takes effect next cycle; expire is high while the count is 1.
// No backpressure; counts down to zero and stops there.
module refi_agu_dly_cnt #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt_q;

   // Load a new delay or count the current one down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - W'(1);
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/refi_agu.sv
// REFI address generator: strided address sequences with init/middle delays and repeats.
// Latency: first address init_delay+1 cycles after accept; one address per ISSUE cycle.
// Accepts only in IDLE (instr_ready); abort cancels next cycle. Optional REFI_AGU_BOUNDS_CHECK_EN adds addr_oob.
module refi_agu
   import refi_agu_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int RF_DEPTH   = DEF_RF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [CNT_WIDTH-1:0]  nr_addrs,
   input  logic [CNT_WIDTH-1:0]  step,
   input  logic                  step_sign,
   input  logic [CNT_WIDTH-1:0]  init_delay,
   input  logic [CNT_WIDTH-1:0]  middle_delay,
   input  logic [CNT_WIDTH-1:0]  num_rept,
   input  logic [ADDR_WIDTH-1:0] rep_step,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  addr_valid,
`ifdef REFI_AGU_BOUNDS_CHECK_EN
   output logic                  addr_oob,
`endif
   output logic                  busy,
   output logic                  done
);

   // Unwrapped offsets are kept wide and signed so out-of-range addresses remain visible.
   localparam int OW = ADDR_WIDTH + CNT_WIDTH + 1;

   refi_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, next_addr, rep_step_q;
   logic signed [OW-1:0]  off_q, off_d, step_ext;
   logic [CNT_WIDTH-1:0]  idx_q, idx_d, rep_q, rep_d;
   logic [CNT_WIDTH-1:0]  nr_q, step_q, mid_q, rept_q, cnt_val;
   logic                  sign_q, cnt_load, cnt_expire, done_c;
   logic                  accept, last_addr, last_rep;

   assign accept    = instr_valid && (state_q == IDLE) && !abort;
   assign last_addr = (idx_q == nr_q);
   assign last_rep  = (rep_q == rept_q);
   assign step_ext  = $signed({{(OW-CNT_WIDTH){1'b0}}, step_q});

   refi_agu_dly_cnt #(.W(CNT_WIDTH)) u_dly_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .expire   (cnt_expire)
   );

   // Next-state, iteration bookkeeping and delay-counter loads.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      off_d    = off_q;
      idx_d    = idx_q;
      rep_d    = rep_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      done_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               base_d = start_addr;
               off_d  = '0;
               idx_d  = '0;
               rep_d  = '0;
               if (init_delay != '0) begin
                  state_d  = INIT_DLY;
                  cnt_load = 1'b1;
                  cnt_val  = init_delay;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         INIT_DLY, MID_DLY: begin
            if (abort)
               state_d = IDLE;
            else if (cnt_expire)
               state_d = ISSUE;
         end
         ISSUE: begin
            done_c = last_addr && last_rep;
            if (abort || (last_addr && last_rep)) begin
               state_d = IDLE;
            end else if (last_addr) begin
               // New iteration follows immediately, no middle delay.
               base_d = base_q + rep_step_q;
               off_d  = '0;
               idx_d  = '0;
               rep_d  = rep_q + CNT_WIDTH'(1);
            end else begin
               idx_d = idx_q + CNT_WIDTH'(1);
               off_d = sign_q ? (off_q - step_ext) : (off_q + step_ext);
               if (mid_q != '0) begin
                  state_d  = MID_DLY;
                  cnt_load = 1'b1;
                  cnt_val  = mid_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign next_addr = base_d + off_d[ADDR_WIDTH-1:0];

   // State, iteration counters and the address register (loaded only when an address issues).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         off_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         if (state_d == ISSUE)
            addr_q <= next_addr;
      end
   end

   // Instruction fields captured on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nr_q       <= '0;
         step_q     <= '0;
         sign_q     <= 1'b0;
         mid_q      <= '0;
         rept_q     <= '0;
         rep_step_q <= '0;
      end else if (accept) begin
         nr_q       <= nr_addrs;
         step_q     <= step;
         sign_q     <= step_sign;
         mid_q      <= middle_delay;
         rept_q     <= num_rept;
         rep_step_q <= rep_step;
      end
   end

`ifdef REFI_AGU_BOUNDS_CHECK_EN
   localparam logic signed [OW-1:0] DEPTH_S = OW'(RF_DEPTH);

   logic signed [OW-1:0] unw_d;
   logic                 oob_q;

   assign unw_d = $signed({{(OW-ADDR_WIDTH){1'b0}}, base_d}) + off_d;

   // Range flag captured alongside the address it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         oob_q <= 1'b0;
      else if (state_d == ISSUE)
         oob_q <= unw_d[OW-1] || (unw_d >= DEPTH_S);
   end

   assign addr_oob = (state_q == ISSUE) && oob_q;
`endif

   assign addr_out    = addr_q;
   assign addr_valid  = (state_q == ISSUE);
   assign done        = done_c;
   assign busy        = (state_q != IDLE);
   assign instr_ready = (state_q == IDLE);

endmodule

// File: tb/tb_refi_agu.sv
// Scoreboard bench for refi_agu: directed instructions push expected addresses.
// A negedge monitor pops and compares cycle, address, done (and addr_oob when enabled).
// Directed checks cover reset, busy window, abort and mid-sequence reset.
module tb_refi_agu;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid, instr_ready, step_sign, abort;
   logic [5:0] start_addr, nr_addrs, step, init_delay, middle_delay, num_rept, rep_step;
   logic [5:0] addr_out;
   logic       addr_valid, busy, done;
`ifdef REFI_AGU_BOUNDS_CHECK_EN
   logic       addr_oob;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [5:0] addr;
      logic       done;
      logic       oob;
   } exp_t;
   exp_t exp_q[$];

   refi_agu dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .start_addr   (start_addr),
      .nr_addrs     (nr_addrs),
      .step         (step),
      .step_sign    (step_sign),
      .init_delay   (init_delay),
      .middle_delay (middle_delay),
      .num_rept     (num_rept),
      .rep_step     (rep_step),
      .abort        (abort),
      .addr_out     (addr_out),
      .addr_valid   (addr_valid),
`ifdef REFI_AGU_BOUNDS_CHECK_EN
      .addr_oob     (addr_oob),
`endif
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int c, input logic [5:0] a, input logic d, input logic o);
      exp_t e;
      e.cyc = c; e.addr = a; e.done = d; e.oob = o;
      exp_q.push_back(e);
   endtask

   // Presents an instruction during cycle t; caller pushes expectations, then calls release_instr.
   task automatic drive(input logic [5:0] sa, input logic [5:0] nr, input logic [5:0] st,
                        input logic sg, input logic [5:0] ini, input logic [5:0] mid,
                        input logic [5:0] rp, input logic [5:0] rs, output int t);
      @(negedge clk); #1;
      start_addr = sa; nr_addrs = nr; step = st; step_sign = sg;
      init_delay = ini; middle_delay = mid; num_rept = rp; rep_step = rs;
      instr_valid = 1'b1;
      t = cyc;
   endtask

   task automatic release_instr();
      @(negedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_ready"}, instr_ready, 1);
      chk({name, "_busy"},  busy,        0);
      chk({name, "_valid"}, addr_valid,  0);
      chk({name, "_done"},  done,        0);
   endtask

   // Monitor: every issued address must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (addr_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual=addr %0d required=no address (cycle %0d)", addr_out, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("addr_cycle", cyc, e.cyc);
               chk("addr_value", addr_out, e.addr);
               chk("addr_done",  done, e.done);
`ifdef REFI_AGU_BOUNDS_CHECK_EN
               chk("addr_oob",   addr_oob, e.oob);
`endif
            end
         end else if (done) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid actual=1 required=0 (cycle %0d)", cyc);
         end
      end
   end

   initial begin
      int t;
      rst = 1'b1; instr_valid = 1'b0; abort = 1'b0; step_sign = 1'b0;
      start_addr = '0; nr_addrs = '0; step = '0; init_delay = '0;
      middle_delay = '0; num_rept = '0; rep_step = '0;
      #1;
      chk("rst_addr_out", addr_out, 0);
      chk_idle("rst");
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;

      // Simple ascending run, no delays.
      drive(6'd4, 6'd3, 6'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, t);
      push(t+1, 6'd4, 0, 0); push(t+2, 6'd5, 0, 0);
      push(t+3, 6'd6, 0, 0); push(t+4, 6'd7, 1, 0);
      release_instr();
      wait_to(t+5);
      chk_idle("s1_after");
      chk("s1_hold_addr", addr_out, 7);

      // Descending stride with initial delay; busy window.
      drive(6'd10, 6'd2, 6'd2, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0, t);
      push(t+4, 6'd10, 0, 0); push(t+5, 6'd8, 0, 0); push(t+6, 6'd6, 1, 0);
      release_instr();
      for (int k = 1; k <= 6; k++) begin
         wait_to(t+k);
         chk("s2_busy", busy, 1);
         chk("s2_ready", instr_ready, 0);
      end
      wait_to(t+2);
      wait_to(t+7);
      chk_idle("s2_after");

      // Middle delay with repeats.
      drive(6'd0, 6'd1, 6'd1, 1'b0, 6'd0, 6'd1, 6'd2, 6'd8, t);
      push(t+1, 6'd0, 0, 0); push(t+3, 6'd1, 0, 0); push(t+4, 6'd8, 0, 0);
      push(t+6, 6'd9, 0, 0); push(t+7, 6'd16, 0, 0); push(t+9, 6'd17, 1, 0);
      release_instr();
      wait_to(t+2);
      chk("s3_gap_hold_addr", addr_out, 0);
      wait_to(t+10);
      chk_idle("s3_after");

      // Upward wrap past the top of the register file.
      drive(6'd62, 6'd3, 6'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, t);
      push(t+1, 6'd62, 0, 0); push(t+2, 6'd63, 0, 0);
      push(t+3, 6'd0, 0, 1);  push(t+4, 6'd1, 1, 1);
      release_instr();
      wait_to(t+6);

      // Downward wrap below zero.
      drive(6'd1, 6'd2, 6'd1, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, t);
      push(t+1, 6'd1, 0, 0); push(t+2, 6'd0, 0, 0); push(t+3, 6'd63, 1, 1);
      release_instr();
      wait_to(t+5);

      // Abort sampled with the second address.
      drive(6'd4, 6'd3, 6'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, t);
      push(t+1, 6'd4, 0, 0); push(t+2, 6'd5, 0, 0);
      release_instr();
      wait_to(t+2);
      abort = 1'b1;
      wait_to(t+3);
      abort = 1'b0;
      chk_idle("abort_next");
      wait_to(t+8);

      // Reset mid-sequence after the second address.
      drive(6'd4, 6'd3, 6'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, t);
      push(t+1, 6'd4, 0, 0); push(t+2, 6'd5, 0, 0);
      release_instr();
      wait_to(t+2);
      rst = 1'b1;
      #1;
      chk("midrst_addr_out", addr_out, 0);
      chk_idle("midrst");
      wait_to(t+4);
      rst = 1'b0;
      wait_to(t+8);
      chk_idle("midrst_after");

      // Abort in IDLE blocks an offered instruction.
      @(negedge clk); #1;
      start_addr = 6'd20; nr_addrs = 6'd1; step = 6'd1; step_sign = 1'b0;
      init_delay = 6'd0; middle_delay = 6'd0; num_rept = 6'd0; rep_step = 6'd0;
      instr_valid = 1'b1; abort = 1'b1;
      @(negedge clk); #1;
      instr_valid = 1'b0; abort = 1'b0;
      chk_idle("idle_abort");
      repeat (4) @(negedge clk);

      // Accept still works after the blocked attempt.
      drive(6'd20, 6'd1, 6'd5, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, t);
      push(t+1, 6'd20, 0, 0); push(t+2, 6'd25, 1, 0);
      release_instr();
      wait_to(t+4);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
